// File: rtl/dffen_bank_pkg.sv
// dffen_bank_pkg: shared types and helpers for the dffen_bank register bank
// Contents: snap_state_e snapshot FSM states, cnt_sat_inc saturating increment.
// Optional feature macro used by the bank: DFFEN_BANK_PARITY_EN.
package dffen_bank_pkg;
  typedef enum logic {IDLE, HOLD} snap_state_e;
  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? cnt : cnt + 32'd1;
  endfunction
endpackage

// File: rtl/dffen_chan.sv
// dffen_chan: one WIDTH-bit enabled register with a saturating change counter
// Ports: clk, rst_n (async active-low), i_en load enable, i_din data in,
//        i_clr counter clear, i_snap_clr snapshot-time counter restart,
//        o_dout registered data, o_cnt change counter,
//        o_dpar registered even parity of o_dout (only with DFFEN_BANK_PARITY_EN).
module dffen_chan
  import dffen_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_clr,
  input  logic             i_snap_clr,
`ifdef DFFEN_BANK_PARITY_EN
  output logic             o_dpar,
`endif
  output logic [WIDTH-1:0] o_dout,
  output logic [CNT_W-1:0] o_cnt
);
  localparam logic [31:0] MAX = 32'({CNT_W{1'b1}});
  logic [WIDTH-1:0] r_dout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_chg;
  logic [CNT_W-1:0] w_inc;
  assign w_chg = i_en && (i_din != r_dout);
  assign w_inc = CNT_W'(cnt_sat_inc(32'(r_cnt), MAX));
  // A snapshot restart keeps the change happening in the capture cycle itself.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_dout <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_en) r_dout <= i_din;
      r_cnt <= i_clr ? '0 : i_snap_clr ? CNT_W'(w_chg) : w_chg ? w_inc : r_cnt;
    end
`ifdef DFFEN_BANK_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_par <= 1'b0;
    else if (i_en) r_par <= ^i_din;
  assign o_dpar = r_par;
`endif
  assign o_dout = r_dout;
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/dffen_bank.sv
// dffen_bank: CHANNELS enabled registers with change counters and a coherent snapshot
// Ports: clk, rst_n (async active-low), en/din per-channel load, dout registered data,
//        clr_cnt counter clear, upd_cnt change counters, snap_req/snap_valid/snap_ready
//        snapshot handshake, snap_data/snap_cnt captured images.
// Optional (DFFEN_BANK_PARITY_EN): dpar per-channel parity, snap_par captured parity.
module dffen_bank
  import dffen_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4,
  parameter bit SNAP_CLR = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS*WIDTH-1:0] dout,
  input  logic                      clr_cnt,
  output logic [CHANNELS*CNT_W-1:0] upd_cnt,
  input  logic                      snap_req,
  output logic                      snap_valid,
  input  logic                      snap_ready,
`ifdef DFFEN_BANK_PARITY_EN
  output logic [CHANNELS-1:0]       dpar,
  output logic [CHANNELS-1:0]       snap_par,
`endif
  output logic [CHANNELS*WIDTH-1:0] snap_data,
  output logic [CHANNELS*CNT_W-1:0] snap_cnt
);
  snap_state_e               r_state, w_next;
  logic                      w_cap, w_acc;
  logic [CHANNELS*WIDTH-1:0] r_snap_data;
  logic [CHANNELS*CNT_W-1:0] r_snap_cnt;
  assign w_cap = (r_state == IDLE) && snap_req;
  assign w_acc = (r_state == HOLD) && snap_ready;
  always_comb begin
    w_next = r_state;
    w_next = w_cap ? HOLD : w_acc ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Images are taken from pre-edge values so they match what readout saw this cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_snap_data <= '0;
      r_snap_cnt  <= '0;
    end else if (w_cap) begin
      r_snap_data <= dout;
      r_snap_cnt  <= upd_cnt;
    end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    dffen_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (en[g]),
      .i_din     (din[g*WIDTH +: WIDTH]),
      .i_clr     (clr_cnt),
      .i_snap_clr(SNAP_CLR && w_cap),
`ifdef DFFEN_BANK_PARITY_EN
      .o_dpar    (dpar[g]),
`endif
      .o_dout    (dout[g*WIDTH +: WIDTH]),
      .o_cnt     (upd_cnt[g*CNT_W +: CNT_W])
    );
  end
`ifdef DFFEN_BANK_PARITY_EN
  logic [CHANNELS-1:0] r_snap_par;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_snap_par <= '0;
    else if (w_cap) r_snap_par <= dpar;
  assign snap_par = r_snap_par;
`endif
  assign snap_valid = (r_state == HOLD);
  assign snap_data  = r_snap_data;
  assign snap_cnt   = r_snap_cnt;
endmodule

// File: tb/tb_dffen_bank.sv
// tb_dffen_bank: scenario tasks with a snapshot/data scoreboard for dffen_bank
module tb_dffen_bank;
  logic        clk = 1'b0, rst_n = 1'b1, clr_cnt = 1'b0, snap_req = 1'b0, snap_ready = 1'b0;
  logic [3:0]  en = '0;
  logic [31:0] din = '0;
  logic [31:0] dout, snap_data;
  logic [15:0] upd_cnt, snap_cnt;
  logic        snap_valid;
`ifdef DFFEN_BANK_PARITY_EN
  logic [3:0]  dpar, snap_par;
`endif
  int n_chk = 0, n_pass = 0;
  logic [31:0] q_snap[$];
  logic [15:0] q_cnt[$];
  logic [7:0]  q_dout[$];
  logic [31:0] e_snap;
  logic [15:0] e_cnt;
  logic [7:0]  e_dout;

  dffen_bank dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .dout(dout),
    .clr_cnt(clr_cnt), .upd_cnt(upd_cnt), .snap_req(snap_req),
    .snap_valid(snap_valid), .snap_ready(snap_ready),
`ifdef DFFEN_BANK_PARITY_EN
    .dpar(dpar), .snap_par(snap_par),
`endif
    .snap_data(snap_data), .snap_cnt(snap_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b1; #1;
    rst_n = 1'b0;
    en = '0; din = '0; clr_cnt = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
    q_snap.delete(); q_cnt.delete(); q_dout.delete();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    en = 4'b0001; din = 32'hA5; tick();
    en = '0; snap_req = 1'b1; tick();
    snap_req = 1'b0;
    n_chk++; if (snap_valid !== 1'b1) $display("FAIL rst_pre_valid got %b want 1", snap_valid); else n_pass++;
    n_chk++; if (dout[7:0] !== 8'hA5) $display("FAIL rst_pre_dout got %h want a5", dout[7:0]); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (snap_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", snap_valid); else n_pass++;
    n_chk++; if (dout !== 32'h0) $display("FAIL rst_dout got %h want 0", dout); else n_pass++;
    n_chk++; if (upd_cnt !== 16'h0) $display("FAIL rst_cnt got %h want 0", upd_cnt); else n_pass++;
    n_chk++; if (snap_data !== 32'h0 || snap_cnt !== 16'h0) $display("FAIL rst_snap got %h/%h want 0/0", snap_data, snap_cnt); else n_pass++;
    rst_n = 1'b1;
    snap_ready = 1'b1; tick();
    n_chk++; if (snap_valid !== 1'b0) $display("FAIL idle_ready got %b want 0", snap_valid); else n_pass++;
    snap_ready = 1'b0; snap_req = 1'b1; tick();
    snap_req = 1'b0;
    n_chk++; if (snap_valid !== 1'b1) $display("FAIL rst_idle_cap got %b want 1", snap_valid); else n_pass++;
    snap_ready = 1'b1; tick();
    snap_ready = 1'b0;
  endtask

  task automatic test_datapath;
    logic [7:0] vals [4] = '{8'h00, 8'h11, 8'h11, 8'h22};
    do_reset();
    en = 4'b0001; din[15:8] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      din[7:0] = vals[i];
      q_dout.push_back(vals[i]);
      tick();
      e_dout = q_dout.pop_front();
      n_chk++; if (dout[7:0] !== e_dout) $display("FAIL dp_dout0[%0d] got %h want %h", i, dout[7:0], e_dout); else n_pass++;
    end
    n_chk++; if (upd_cnt[3:0] !== 4'd2) $display("FAIL dp_cnt0 got %0d want 2", upd_cnt[3:0]); else n_pass++;
    n_chk++; if (dout[15:8] !== 8'h00 || upd_cnt[7:4] !== 4'd0) $display("FAIL dp_ch1_hold got %h/%0d want 00/0", dout[15:8], upd_cnt[7:4]); else n_pass++;
  endtask

  task automatic test_saturate;
    do_reset();
    en = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      din[23:16] = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
      if (i == 13) begin
        n_chk++; if (upd_cnt[11:8] !== 4'd14) $display("FAIL sat_mid got %0d want 14", upd_cnt[11:8]); else n_pass++;
      end
    end
    n_chk++; if (upd_cnt[11:8] !== 4'd15) $display("FAIL sat_top got %0d want 15", upd_cnt[11:8]); else n_pass++;
    clr_cnt = 1'b1; din[23:16] = 8'h5A; tick();
    clr_cnt = 1'b0; en = '0;
    n_chk++; if (upd_cnt[11:8] !== 4'd0) $display("FAIL sat_clr got %0d want 0", upd_cnt[11:8]); else n_pass++;
    n_chk++; if (dout[23:16] !== 8'h5A) $display("FAIL sat_clr_dout got %h want 5a", dout[23:16]); else n_pass++;
  endtask

  task automatic test_snapshot;
    do_reset();
    en = 4'hF; din = 32'h04030201; tick();
    en = '0; snap_req = 1'b1;
    q_snap.push_back(32'h04030201); q_cnt.push_back(16'h1111);
    tick();
    snap_req = 1'b0;
    n_chk++; if (upd_cnt !== 16'h0) $display("FAIL snap_clr_all got %h want 0", upd_cnt); else n_pass++;
    en = 4'hF;
    for (int i = 0; i < 5; i++) begin
      din = $urandom;
      tick();
      n_chk++; if (snap_valid !== 1'b1) $display("FAIL snap_hold_valid[%0d] got %b want 1", i, snap_valid); else n_pass++;
      n_chk++; if (snap_data !== q_snap[0] || snap_cnt !== q_cnt[0]) $display("FAIL snap_frozen[%0d] got %h/%h want %h/%h", i, snap_data, snap_cnt, q_snap[0], q_cnt[0]); else n_pass++;
    end
    en = '0; snap_ready = 1'b1;
    e_snap = q_snap.pop_front(); e_cnt = q_cnt.pop_front();
    n_chk++; if (snap_data !== e_snap || snap_cnt !== e_cnt) $display("FAIL snap_accept got %h/%h want %h/%h", snap_data, snap_cnt, e_snap, e_cnt); else n_pass++;
    tick();
    snap_ready = 1'b0;
    n_chk++; if (snap_valid !== 1'b0) $display("FAIL snap_drop got %b want 0", snap_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    en = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      din[7:0] = 8'(i);
      tick();
    end
    n_chk++; if (upd_cnt[3:0] !== 4'd3) $display("FAIL b2b_pre_cnt got %0d want 3", upd_cnt[3:0]); else n_pass++;
    snap_req = 1'b1; din[7:0] = 8'h04;
    q_snap.push_back(32'h00000003); q_cnt.push_back(16'h0003);
    tick();
    n_chk++; if (upd_cnt[3:0] !== 4'd1) $display("FAIL b2b_snapclr_cnt got %0d want 1", upd_cnt[3:0]); else n_pass++;
    n_chk++; if (snap_valid !== 1'b1 || dout[7:0] !== 8'h04) $display("FAIL b2b_cap got %b/%h want 1/04", snap_valid, dout[7:0]); else n_pass++;
    snap_ready = 1'b1; din[7:0] = 8'h05;
    e_snap = q_snap.pop_front(); e_cnt = q_cnt.pop_front();
    n_chk++; if (snap_data !== e_snap || snap_cnt !== e_cnt) $display("FAIL b2b_snap1 got %h/%h want %h/%h", snap_data, snap_cnt, e_snap, e_cnt); else n_pass++;
    tick();
    n_chk++; if (snap_valid !== 1'b0) $display("FAIL b2b_no_recap got %b want 0", snap_valid); else n_pass++;
    en = '0; snap_ready = 1'b0;
    q_snap.push_back(32'h00000005); q_cnt.push_back(16'h0002);
    tick();
    snap_req = 1'b0;
    e_snap = q_snap.pop_front(); e_cnt = q_cnt.pop_front();
    n_chk++; if (snap_valid !== 1'b1) $display("FAIL b2b_recap got %b want 1", snap_valid); else n_pass++;
    n_chk++; if (snap_data !== e_snap || snap_cnt !== e_cnt) $display("FAIL b2b_snap2 got %h/%h want %h/%h", snap_data, snap_cnt, e_snap, e_cnt); else n_pass++;
    n_chk++; if (upd_cnt[3:0] !== 4'd0) $display("FAIL b2b_post_cnt got %0d want 0", upd_cnt[3:0]); else n_pass++;
    snap_ready = 1'b1; tick();
    snap_ready = 1'b0;
    n_chk++; if (snap_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", snap_valid); else n_pass++;
  endtask

`ifdef DFFEN_BANK_PARITY_EN
  task automatic test_parity;
    do_reset();
    en = 4'b1000; din[31:24] = 8'h07; tick();
    en = '0;
    n_chk++; if (dpar !== 4'b1000) $display("FAIL par_dpar got %b want 1000", dpar); else n_pass++;
    snap_req = 1'b1; tick();
    snap_req = 1'b0;
    n_chk++; if (snap_par !== 4'b1000) $display("FAIL par_snap got %b want 1000", snap_par); else n_pass++;
    snap_ready = 1'b1; tick();
    snap_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_datapath();
    test_saturate();
    test_snapshot();
    test_back_to_back();
`ifdef DFFEN_BANK_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
